serdes_link: RTL and testbench

//  Parametrised single-lane SerDes link: serialises DATA_W-bit words into framed bit stream, deserialises and block-aligns

---
 rtl/serdes_pkg.sv | 18 +
 rtl/serdes_rx_align.sv | 121 ++++++++++++
 rtl/serdes_link.sv | 80 ++++++++
 tb/tb_serdes_link.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared frame headers, alignment state type and counter sizing helper
// for the single-lane SerDes link.
package serdes_pkg;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_IDLE = 2'b10;

    typedef enum logic {
        HUNT,
        LOCKED
    } align_state_t;

    // Bits needed to hold 0..maxVal inclusive, with headroom so compares never truncate.
    function automatic int cntWidth(input int maxVal);
        return $clog2(maxVal) + 1;
    endfunction

endpackage

// File: rtl/serdes_rx_align.sv
// Receive side of the lane: frame-wide shift window, bit-slip block alignment,
// lock tracking and recovered-word outputs.
module serdes_rx_align
    import serdes_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_rx_locked,
    output logic              o_rx_err
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = cntWidth(FRAME_W - 1);
    localparam int GOOD_W  = cntWidth(LOCK_CNT);
    localparam int BAD_W   = cntWidth(UNLOCK_CNT);

    align_state_t        r_state, w_stateNxt;
    logic [FRAME_W-2:0]  r_sreg;
    logic [CNT_W-1:0]    r_cnt, w_cntNxt;
    logic [GOOD_W-1:0]   r_goodCnt, w_goodNxt;
    logic [BAD_W-1:0]    r_badCnt, w_badNxt;
    logic [DATA_W-1:0]   r_data, w_dataNxt;
    logic                r_valid, w_validNxt;
    logic                r_err, w_errNxt;

    logic [FRAME_W-1:0]  w_win;
    logic [1:0]          w_hdr;
    logic [DATA_W-1:0]   w_pay;
    logic                w_check, w_goodIdle, w_badHdr;

    assign w_win      = {r_sreg, i_bit};
    assign w_hdr      = w_win[FRAME_W-1 -: 2];
    assign w_pay      = w_win[DATA_W-1:0];
    assign w_check    = (r_cnt == CNT_W'(FRAME_W - 1));
    assign w_goodIdle = (w_hdr == HDR_IDLE) && (w_pay == '0);
    assign w_badHdr   = (w_hdr != HDR_DATA) && (w_hdr != HDR_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= HUNT;
        else       r_state <= w_stateNxt;
    end

    always_comb begin
        w_stateNxt = r_state;
        case (r_state)
            HUNT:
                if (w_check && w_goodIdle && (r_goodCnt == GOOD_W'(LOCK_CNT - 1)))
                    w_stateNxt = LOCKED;
            LOCKED:
                if (w_check && w_badHdr && (r_badCnt == BAD_W'(UNLOCK_CNT - 1)))
                    w_stateNxt = HUNT;
            default: w_stateNxt = HUNT;
        endcase
    end

    // In HUNT a failed check leaves the counter parked, so the next check is one bit later (slip).
    always_comb begin
        w_cntNxt   = w_check ? r_cnt : r_cnt + 1'b1;
        w_goodNxt  = r_goodCnt;
        w_badNxt   = r_badCnt;
        w_dataNxt  = r_data;
        w_validNxt = 1'b0;
        w_errNxt   = 1'b0;
        if (w_check) begin
            if (r_state == HUNT) begin
                if (w_goodIdle) begin
                    w_cntNxt  = '0;
                    w_goodNxt = (w_stateNxt == LOCKED) ? '0 : r_goodCnt + 1'b1;
                end else begin
                    w_goodNxt = '0;
                end
            end else begin
                w_cntNxt = '0;
                if (w_hdr == HDR_DATA) begin
                    w_validNxt = 1'b1;
                    w_dataNxt  = w_pay;
                    w_badNxt   = '0;
                end else if (w_hdr == HDR_IDLE) begin
                    w_badNxt = '0;
                end else begin
                    w_errNxt  = 1'b1;
                    w_badNxt  = (w_stateNxt == HUNT) ? '0 : r_badCnt + 1'b1;
                    w_goodNxt = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg    <= '0;
            r_cnt     <= '0;
            r_goodCnt <= '0;
            r_badCnt  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sreg    <= w_win[FRAME_W-2:0];
            r_cnt     <= w_cntNxt;
            r_goodCnt <= w_goodNxt;
            r_badCnt  <= w_badNxt;
            r_data    <= w_dataNxt;
            r_valid   <= w_validNxt;
            r_err     <= w_errNxt;
        end
    end

    assign o_rx_data   = r_data;
    assign o_rx_valid  = r_valid;
    assign o_rx_err    = r_err;
    assign o_rx_locked = (r_state == LOCKED);

endmodule

// File: rtl/serdes_link.sv
// Single-lane SerDes core: framing serialiser with idle insertion and
// valid/ready flow control, plus the aligning deserialiser with loopback.
module serdes_link
    import serdes_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int IDLE_MIN   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_ser_out,
    input  logic              i_ser_in,
    input  logic              i_loopback,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_rx_locked,
    output logic              o_rx_err
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int TXCNT_W = cntWidth(FRAME_W - 1);
    localparam int IDLE_W  = cntWidth(IDLE_MIN);

    logic [TXCNT_W-1:0] r_txCnt;
    logic [IDLE_W-1:0]  r_idleCnt;
    logic [FRAME_W-1:0] r_txShreg;
    logic               w_txLoad;
    logic               w_txReady;
    logic               w_accept;
    logic               w_rxBit;

    assign w_txLoad  = (r_txCnt == TXCNT_W'(FRAME_W - 1));
    assign w_txReady = w_txLoad && (r_idleCnt == IDLE_W'(IDLE_MIN)) && !i_rst;
    assign w_accept  = i_tx_valid && w_txReady;

    // Words are only taken on a frame-load edge, so nothing is ever dropped mid-frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_txCnt   <= TXCNT_W'(FRAME_W - 1);
            r_idleCnt <= '0;
            r_txShreg <= '0;
        end else if (w_txLoad) begin
            r_txCnt <= '0;
            if (w_accept) begin
                r_txShreg <= {HDR_DATA, i_tx_data};
            end else begin
                r_txShreg <= {HDR_IDLE, {DATA_W{1'b0}}};
                if (r_idleCnt != IDLE_W'(IDLE_MIN))
                    r_idleCnt <= r_idleCnt + 1'b1;
            end
        end else begin
            r_txCnt   <= r_txCnt + 1'b1;
            r_txShreg <= {r_txShreg[FRAME_W-2:0], 1'b0};
        end
    end

    assign o_ser_out  = r_txShreg[FRAME_W-1];
    assign o_tx_ready = w_txReady;
    assign w_rxBit    = i_loopback ? r_txShreg[FRAME_W-1] : i_ser_in;

    serdes_rx_align #(
        .DATA_W     (DATA_W),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_rxAlign (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_bit       (w_rxBit),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_rx_locked (o_rx_locked),
        .o_rx_err    (o_rx_err)
    );

endmodule

// File: tb/tb_serdes_link.sv
// Directed self-checking bench for serdes_link: lock timing, idle preamble,
// loopback and external-path data recovery, lock loss and mid-frame reset.
module tb_serdes_link;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] txData;
    logic        txValid;
    logic        txReady;
    logic        serOut;
    logic        serIn;
    logic        loopback;
    logic [31:0] rxData;
    logic        rxValid;
    logic        rxLocked;
    logic        rxErr;

    logic        serInMode;
    logic        serInBit;
    logic [4:0]  dly = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] rxQ[$];
    int          rxCycQ[$];
    int          errCycQ[$];

    always #5 clk = ~clk;

    assign serIn = serInMode ? dly[4] : serInBit;

    serdes_link dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tx_data   (txData),
        .i_tx_valid  (txValid),
        .o_tx_ready  (txReady),
        .o_ser_out   (serOut),
        .i_ser_in    (serIn),
        .i_loopback  (loopback),
        .o_rx_data   (rxData),
        .o_rx_valid  (rxValid),
        .o_rx_locked (rxLocked),
        .o_rx_err    (rxErr)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dly <= {dly[3:0], serOut};
    end

    always @(negedge clk) begin
        if (rxValid) begin
            rxQ.push_back(rxData);
            rxCycQ.push_back(cyc);
        end
        if (rxErr) errCycQ.push_back(cyc);
    end

    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                                 input logic lb, input logic mode, input logic b);
        rst       = r;
        txValid   = v;
        txData    = d;
        loopback  = lb;
        serInMode = mode;
        serInBit  = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic condMet(input int which);
        case (which)
            0:       return rxLocked === 1'b1;
            1:       return rxLocked === 1'b0;
            default: return txReady === 1'b1;
        endcase
    endfunction

    task automatic waitFor(input int which, input int bound, output int n);
        n = 0;
        while (n < bound && !condMet(which)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic sendWord(input logic [31:0] w, output int acceptEdge);
        txValid    = 1'b1;
        txData     = w;
        acceptEdge = -1000;
        for (int n = 0; n < 400 && acceptEdge < 0; n++) begin
            if (txReady) acceptEdge = cyc + 1;
            @(negedge clk);
        end
        txValid = 1'b0;
    endtask

    function automatic int rxLatency(input int idx, input int acceptEdge);
        if (idx < rxCycQ.size()) return rxCycQ[idx] - acceptEdge;
        return -1;
    endfunction

    function automatic logic [31:0] rxWord(input int idx);
        if (idx < rxQ.size()) return rxQ[idx];
        return 32'hxxxx_xxxx;
    endfunction

    initial begin
        int n;
        int nReady;
        int acc0;
        int acc1;
        int relocks;
        logic [31:0] expQ[$];
        logic [31:0] w;

        // Reset state with loopback and no traffic
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("rst_tx_ready", txReady, 0);
        checkOutput("rst_ser_out", serOut, 0);
        checkOutput("rst_rx_valid", rxValid, 0);
        checkOutput("rst_rx_locked", rxLocked, 0);
        checkOutput("rst_rx_err", rxErr, 0);
        checkOutput("rst_rx_data", rxData, 0);

        // Lock on idles: slip once, then 4 good idles -> edge 35 + 3*34 = 137
        rst = 1'b0;
        waitFor(0, 300, n);
        checkOutput("t1_lock_cycle", n, 137);
        waitFor(2, 300, nReady);
        checkOutput("t1_ready_cycle", n + nReady, 272);
        checkOutput("t1_no_rx_valid", rxQ.size(), 0);
        checkOutput("t1_no_rx_err", errCycQ.size(), 0);

        // tx_valid held from reset: accept only after 8 idle frames
        applyStimulus(1'b1, 1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        rxQ.delete();
        rxCycQ.delete();
        rst = 1'b0;
        waitFor(2, 400, n);
        checkOutput("t2_first_ready", n, 272);
        acc0 = cyc + 1;
        @(negedge clk);
        txValid = 1'b0;
        waitCycles(50);
        checkOutput("t2_rx_count", rxQ.size(), 1);
        checkOutput("t2_rx_data", rxWord(0), 32'hAAAA_AAAA);
        checkOutput("t2_latency", rxLatency(0, acc0), 34);

        // Back-to-back words through loopback
        rxQ.delete();
        rxCycQ.delete();
        sendWord(32'h0123_4567, acc0);
        sendWord(32'h5555_5555, acc1);
        checkOutput("t3_back_to_back", acc1 - acc0, 34);
        waitCycles(50);
        checkOutput("t3_rx_count", rxQ.size(), 2);
        checkOutput("t3_data0", rxWord(0), 32'h0123_4567);
        checkOutput("t3_data1", rxWord(1), 32'h5555_5555);
        checkOutput("t3_latency0", rxLatency(0, acc0), 34);
        checkOutput("t3_latency1", rxLatency(1, acc1), 34);

        // External path delayed 5 bits: lose lock, realign, recover one word
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        waitFor(1, 300, n);
        waitFor(0, 400, n);
        checkOutput("t4_relocked", rxLocked, 1);
        rxQ.delete();
        rxCycQ.delete();
        sendWord(32'hDEAD_BEEF, acc0);
        waitCycles(60);
        checkOutput("t4_rx_count", rxQ.size(), 1);
        checkOutput("t4_rx_data", rxWord(0), 32'hDEAD_BEEF);
        checkOutput("t4_latency", rxLatency(0, acc0), 39);

        // Dead line: three error pulses a frame apart, then no relock
        errCycQ.delete();
        rxQ.delete();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        waitFor(1, 200, n);
        checkOutput("t5_unlocked", rxLocked, 0);
        relocks = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rxLocked) relocks++;
        end
        checkOutput("t5_no_relock", relocks, 0);
        checkOutput("t5_err_count", errCycQ.size(), 3);
        if (errCycQ.size() == 3) begin
            checkOutput("t5_err_gap1", errCycQ[1] - errCycQ[0], 34);
            checkOutput("t5_err_gap2", errCycQ[2] - errCycQ[1], 34);
        end
        checkOutput("t5_no_rx_valid", rxQ.size(), 0);
        loopback = 1'b1;
        waitFor(0, 400, n);
        checkOutput("t5_restored_lock", rxLocked, 1);

        // One-cycle reset in the middle of a data frame
        rxQ.delete();
        rxCycQ.delete();
        sendWord(32'h1357_9BDF, acc0);
        waitCycles(17);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_tx_ready", txReady, 0);
        checkOutput("t6_ser_out", serOut, 0);
        checkOutput("t6_rx_valid", rxValid, 0);
        checkOutput("t6_rx_locked", rxLocked, 0);
        checkOutput("t6_rx_err", rxErr, 0);
        checkOutput("t6_rx_data", rxData, 0);
        rst = 1'b0;
        waitFor(0, 300, n);
        checkOutput("t6_lock_cycle", n, 137);
        waitCycles(100);
        checkOutput("t6_cut_word_dropped", rxQ.size(), 0);
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            expQ.push_back(w);
            sendWord(w, acc0);
        end
        waitCycles(60);
        checkOutput("t6_rx_count", rxQ.size(), 10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t6_word%0d", i), rxWord(i), expQ[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
